// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared timing constants for the VGA raster generator (640x480@60 with a
//   25 MHz pixel clock), the packed sync bundle carried through the output
//   delay line, and a helper that sums the four segments of a line or frame.
//   No ports; imported by vga_timing_gen and sync_delay_line.
package vga_timing_pkg;

  // Default 640x480@60 horizontal timing, in pixels
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;

  // Default 640x480@60 vertical timing, in lines
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Counter width; both totals must fit below 2**COUNT_W
  localparam int COUNT_W   = 10;
  localparam int MAX_TOTAL = 1 << COUNT_W;

  // Bundle of the signals that travel through the sync delay line.
  // Packed order {hsN, vsN, active} makes the idle value 3'b110.
  typedef struct packed {
    logic hsN;
    logic vsN;
    logic active;
  } sync_bits_t;

  localparam sync_bits_t SYNC_IDLE = '{hsN: 1'b1, vsN: 1'b1, active: 1'b0};

  // Total period of one line or frame from its four segments
  function automatic int calcTotal(input int activeLen, input int fpLen,
                                   input int syncLen, input int bpLen);
    return activeLen + fpLen + syncLen + bpLen;
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// sync_delay_line
//   Fixed-depth shift register with synchronous reset. Every stage loads
//   RESET_VAL on reset so that nothing stale leaks out after reset.
// Ports
//   clk_i  in   1      clock, rising edge
//   rst_i  in   1      synchronous active-high reset
//   d_i    in   WIDTH  data into the first stage
//   q_o    out  WIDTH  data out of the last stage (DEPTH cycles later)
module sync_delay_line
  import vga_timing_pkg::*;
#(
  parameter int               WIDTH     = 3,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= RESET_VAL;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Free-running VGA raster timing generator. Holds the horizontal and
//   vertical pixel counters, decodes sync/active from them, and delays
//   sync/active by SYNC_DELAY cycles so they line up with renderers that
//   register their colour output. line_start/frame_start are undelayed and
//   aligned with x_count/y_count.
// Ports
//   clk_25MHz     in   1   pixel clock, rising edge
//   rst           in   1   synchronous active-high reset
//   x_count       out  10  horizontal counter 0..H_TOTAL-1
//   y_count       out  10  vertical counter 0..V_TOTAL-1
//   hsync         out  1   active-low horizontal sync, delayed
//   vsync         out  1   active-low vertical sync, delayed
//   active_video  out  1   delayed visible-area flag
//   line_start    out  1   high while x_count==0
//   frame_start   out  1   high while x_count==0 and y_count==0
//   frame_count   out  8   completed frames, wraps 255->0
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter int SYNC_DELAY = 1
) (
  input  logic               clk_25MHz,
  input  logic               rst,
  output logic [COUNT_W-1:0] x_count,
  output logic [COUNT_W-1:0] y_count,
  output logic               hsync,
  output logic               vsync,
  output logic               active_video,
  output logic               line_start,
  output logic               frame_start,
  output logic [7:0]         frame_count
);

  localparam int H_TOTAL = calcTotal(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = calcTotal(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (H_TOTAL > MAX_TOTAL) begin : gen_h_total_check
    $error("vga_timing_gen: H_TOTAL exceeds counter range");
  end
  if (V_TOTAL > MAX_TOTAL) begin : gen_v_total_check
    $error("vga_timing_gen: V_TOTAL exceeds counter range");
  end
  if (SYNC_DELAY < 1 || SYNC_DELAY > 4) begin : gen_delay_check
    $error("vga_timing_gen: SYNC_DELAY must be 1..4");
  end

  localparam logic [COUNT_W-1:0] H_LAST       = COUNT_W'(H_TOTAL - 1);
  localparam logic [COUNT_W-1:0] V_LAST       = COUNT_W'(V_TOTAL - 1);
  localparam logic [COUNT_W-1:0] H_ACT_END    = COUNT_W'(H_ACTIVE);
  localparam logic [COUNT_W-1:0] V_ACT_END    = COUNT_W'(V_ACTIVE);
  localparam logic [COUNT_W-1:0] H_SYNC_BEGIN = COUNT_W'(H_ACTIVE + H_FP);
  localparam logic [COUNT_W-1:0] H_SYNC_END   = COUNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COUNT_W-1:0] V_SYNC_BEGIN = COUNT_W'(V_ACTIVE + V_FP);
  localparam logic [COUNT_W-1:0] V_SYNC_END   = COUNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [COUNT_W-1:0] xCount_q, xCount_d;
  logic [COUNT_W-1:0] yCount_q, yCount_d;
  logic [7:0]         frameCount_q, frameCount_d;
  logic               xLast, yLast;
  sync_bits_t         syncRaw, syncDly;

  // Raster advance: x wraps at end of line and carries into y; the frame
  // counter ticks on the single edge where both wrap back to (0,0).
  always_comb begin
    xLast        = (xCount_q == H_LAST);
    yLast        = (yCount_q == V_LAST);
    xCount_d     = xCount_q + COUNT_W'(1);
    yCount_d     = yCount_q;
    frameCount_d = frameCount_q;
    if (xLast) begin
      xCount_d = '0;
      if (yLast) begin
        yCount_d     = '0;
        frameCount_d = frameCount_q + 8'd1;
      end else begin
        yCount_d = yCount_q + COUNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_25MHz) begin
    if (rst) begin
      xCount_q     <= '0;
      yCount_q     <= '0;
      frameCount_q <= '0;
    end else begin
      xCount_q     <= xCount_d;
      yCount_q     <= yCount_d;
      frameCount_q <= frameCount_d;
    end
  end

  // Undelayed decode of the counter registers
  always_comb begin
    syncRaw        = SYNC_IDLE;
    syncRaw.hsN    = !((xCount_q >= H_SYNC_BEGIN) && (xCount_q < H_SYNC_END));
    syncRaw.vsN    = !((yCount_q >= V_SYNC_BEGIN) && (yCount_q < V_SYNC_END));
    syncRaw.active = (xCount_q < H_ACT_END) && (yCount_q < V_ACT_END);
  end

  // Even with SYNC_DELAY=1 this is the output register, so the board pins
  // never see decode glitches.
  sync_delay_line #(
    .WIDTH     (3),
    .DEPTH     (SYNC_DELAY),
    .RESET_VAL (SYNC_IDLE)
  ) u_sync_delay (
    .clk_i (clk_25MHz),
    .rst_i (rst),
    .d_i   (syncRaw),
    .q_o   (syncDly)
  );

  assign x_count      = xCount_q;
  assign y_count      = yCount_q;
  assign frame_count  = frameCount_q;
  assign hsync        = syncDly.hsN;
  assign vsync        = syncDly.vsN;
  assign active_video = syncDly.active;
  assign line_start   = (xCount_q == '0);
  assign frame_start  = (xCount_q == '0) && (yCount_q == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
//   Directed bench for vga_timing_gen. Three instances share clock and reset:
//   default 640x480 timing with SYNC_DELAY=1 (D) and SYNC_DELAY=3 (T), and a
//   tiny 8x6 raster (S) so frame-level behaviour fits in a short run.
//   Small raster: H 4+1+2+1=8, V 3+1+1+1=6, 48 cycles per frame.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  logic [9:0] xD, yD, xT, yT, xS, yS;
  logic       hsD, vsD, actD, lsD, fsD;
  logic       hsT, vsT, actT, lsT, fsT;
  logic       hsS, vsS, actS, lsS, fsS;
  logic [7:0] fcD, fcT, fcS;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  vga_timing_gen #(.SYNC_DELAY(1)) dutD (
    .clk_25MHz(clk), .rst(rst), .x_count(xD), .y_count(yD), .hsync(hsD),
    .vsync(vsD), .active_video(actD), .line_start(lsD), .frame_start(fsD),
    .frame_count(fcD)
  );

  vga_timing_gen #(.SYNC_DELAY(3)) dutT (
    .clk_25MHz(clk), .rst(rst), .x_count(xT), .y_count(yT), .hsync(hsT),
    .vsync(vsT), .active_video(actT), .line_start(lsT), .frame_start(fsT),
    .frame_count(fcT)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_DELAY(1)
  ) dutS (
    .clk_25MHz(clk), .rst(rst), .x_count(xS), .y_count(yS), .hsync(hsS),
    .vsync(vsS), .active_video(actS), .line_start(lsS), .frame_start(fsS),
    .frame_count(fcS)
  );

  // One clock edge; inputs change and outputs are sampled 1 time unit later.
  // cyc counts edges since the last edge that saw reset.
  task automatic step();
    @(posedge clk);
    #1;
    if (rst) cyc = 0;
    else     cyc++;
  endtask

  // Expected {hsync, vsync, active} of a default-timing instance, depth n
  function automatic logic [2:0] expDefault(input int c, input int n);
    int p, x, y;
    if (c < n) return 3'b110;
    p = c - n;
    x = p % 800;
    y = (p / 800) % 525;
    return {!(x >= 656 && x < 752), !(y >= 490 && y < 492), (x < 640 && y < 480)};
  endfunction

  // Expected {hsync, vsync, active} of the small instance (depth 1)
  function automatic logic [2:0] expSmall(input int c);
    int p, x, y;
    if (c < 1) return 3'b110;
    p = c - 1;
    x = p % 8;
    y = (p / 8) % 6;
    return {!(x >= 5 && x < 7), !(y == 4), (x < 4 && y < 3)};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (5) step();
    checks++;
    if ({xD, yD} !== 20'd0) begin
      failures++;
      $display("[TB] FAIL reset_xy got x=%0d y=%0d exp x=0 y=0", xD, yD);
    end
    checks++;
    if ({hsD, vsD, actD} !== 3'b110) begin
      failures++;
      $display("[TB] FAIL reset_sync got hs/vs/act=%b exp=110", {hsD, vsD, actD});
    end
    checks++;
    if ({lsD, fsD} !== 2'b11) begin
      failures++;
      $display("[TB] FAIL reset_strobes got ls/fs=%b exp=11", {lsD, fsD});
    end
    checks++;
    if (fcD !== 8'd0) begin
      failures++;
      $display("[TB] FAIL reset_frame_count got=%0d exp=0", fcD);
    end
    checks++;
    if ({hsT, vsT, actT, hsS, vsS, actS} !== 6'b110110) begin
      failures++;
      $display("[TB] FAIL reset_other_sync got=%b exp=110110", {hsT, vsT, actT, hsS, vsS, actS});
    end
  endtask

  task automatic test_release();
    rst = 1'b0;
    step();
    checks++;
    if ({xD, yD} !== {10'd1, 10'd0}) begin
      failures++;
      $display("[TB] FAIL first_edge_xy got x=%0d y=%0d exp x=1 y=0", xD, yD);
    end
    checks++;
    if ({lsD, fsD, hsD, vsD, actD} !== 5'b00111) begin
      failures++;
      $display("[TB] FAIL first_edge_flags got ls/fs/hs/vs/act=%b exp=00111", {lsD, fsD, hsD, vsD, actD});
    end
  endtask

  // Cycle-by-cycle trace of all three instances over two lines, plus
  // measurements of hsync/active edges on line 1 (cycles 801..1600).
  task automatic test_line_timing();
    int misD = 0, misT = 0, misS = 0;
    int firstD = -1, firstT = -1, firstS = -1;
    int hsLow = 0, actHigh = 0;
    int hsFallX = -1, hsRiseX = -1, actFallX = -1, hsFallXT = -1;
    logic [9:0] ex, ey, sx, sy;
    while (cyc < 1700) begin
      step();
      ex = 10'(cyc % 800);
      ey = 10'((cyc / 800) % 525);
      if ({xD, yD, lsD, fsD, fcD} !== {ex, ey, ex == 10'd0, ex == 10'd0 && ey == 10'd0, 8'd0} ||
          {hsD, vsD, actD} !== expDefault(cyc, 1)) begin
        misD++;
        if (firstD < 0) firstD = cyc;
      end
      if ({xT, yT, hsT, vsT, actT} !== {ex, ey, expDefault(cyc, 3)}) begin
        misT++;
        if (firstT < 0) firstT = cyc;
      end
      sx = 10'(cyc % 8);
      sy = 10'((cyc / 8) % 6);
      if ({xS, yS, lsS, fsS, fcS} !== {sx, sy, sx == 10'd0, sx == 10'd0 && sy == 10'd0, 8'((cyc / 48) % 256)} ||
          {hsS, vsS, actS} !== expSmall(cyc)) begin
        misS++;
        if (firstS < 0) firstS = cyc;
      end
      if (cyc >= 801 && cyc <= 1600) begin
        if (!hsD) hsLow++;
        if (actD) actHigh++;
        if (!hsD && hsFallX < 0) hsFallX = int'(xD);
        if (hsD && hsFallX >= 0 && hsRiseX < 0) hsRiseX = int'(xD);
        if (!actD && actFallX < 0) actFallX = int'(xD);
        if (!hsT && hsFallXT < 0) hsFallXT = int'(xT);
      end
    end
    checks++;
    if (misD !== 0) begin
      failures++;
      $display("[TB] FAIL trace_delay1 got mismatches=%0d first_cycle=%0d exp=0", misD, firstD);
    end
    checks++;
    if (misT !== 0) begin
      failures++;
      $display("[TB] FAIL trace_delay3 got mismatches=%0d first_cycle=%0d exp=0", misT, firstT);
    end
    checks++;
    if (misS !== 0) begin
      failures++;
      $display("[TB] FAIL trace_small got mismatches=%0d first_cycle=%0d exp=0", misS, firstS);
    end
    checks++;
    if (hsLow !== 96) begin
      failures++;
      $display("[TB] FAIL hsync_width got=%0d exp=96", hsLow);
    end
    checks++;
    if (hsFallX !== 657 || hsRiseX !== 753) begin
      failures++;
      $display("[TB] FAIL hsync_edges got fall_x=%0d rise_x=%0d exp 657 753", hsFallX, hsRiseX);
    end
    checks++;
    if (actHigh !== 640 || actFallX !== 641) begin
      failures++;
      $display("[TB] FAIL active_line got count=%0d fall_x=%0d exp 640 641", actHigh, actFallX);
    end
    checks++;
    if (hsFallXT !== 659) begin
      failures++;
      $display("[TB] FAIL hsync_delay3_fall got x=%0d exp=659", hsFallXT);
    end
  endtask

  // One whole small frame: vsync width/position, active count, frame period
  task automatic test_small_frame();
    int vsLow = 0, actHigh = 0, period = 0;
    int vsFallX = -1, vsFallY = -1;
    for (int i = 0; i < 48 && (cyc % 48) != 0; i++) step();
    checks++;
    if (fsS !== 1'b1 || xS !== 10'd0 || yS !== 10'd0) begin
      failures++;
      $display("[TB] FAIL small_frame_align got fs=%b x=%0d y=%0d exp 1 0 0", fsS, xS, yS);
    end
    for (int i = 0; i < 100; i++) begin
      step();
      period++;
      if (!vsS) vsLow++;
      if (actS) actHigh++;
      if (!vsS && vsFallX < 0) begin
        vsFallX = int'(xS);
        vsFallY = int'(yS);
      end
      if (fsS) break;
    end
    checks++;
    if (period !== 48) begin
      failures++;
      $display("[TB] FAIL frame_start_period got=%0d exp=48", period);
    end
    checks++;
    if (vsLow !== 8 || vsFallX !== 1 || vsFallY !== 4) begin
      failures++;
      $display("[TB] FAIL vsync_small got low=%0d fall x=%0d y=%0d exp 8 1 4", vsLow, vsFallX, vsFallY);
    end
    checks++;
    if (actHigh !== 12) begin
      failures++;
      $display("[TB] FAIL active_frame_small got=%0d exp=12", actHigh);
    end
  endtask

  // Run the small raster through 256 frames and watch frame_count wrap
  task automatic test_frame_wrap();
    while (cyc < 12287) step();
    checks++;
    if ({fcS, xS, yS} !== {8'd255, 10'd7, 10'd5}) begin
      failures++;
      $display("[TB] FAIL pre_wrap got fc=%0d x=%0d y=%0d exp 255 7 5", fcS, xS, yS);
    end
    step();
    checks++;
    if ({fcS, xS, yS, fsS} !== {8'd0, 10'd0, 10'd0, 1'b1}) begin
      failures++;
      $display("[TB] FAIL frame_count_wrap got fc=%0d x=%0d y=%0d fs=%b exp 0 0 0 1", fcS, xS, yS, fsS);
    end
    checks++;
    if ({fcD, xD, yD} !== {8'd0, 10'd288, 10'd15}) begin
      failures++;
      $display("[TB] FAIL default_position got fc=%0d x=%0d y=%0d exp 0 288 15", fcD, xD, yD);
    end
  endtask

  // Reset asserted while the small raster is inside both hsync and vsync
  task automatic test_reset_midsync();
    bit found = 1'b0;
    repeat (48) step();
    for (int i = 0; i < 60; i++) begin
      if (xS == 10'd6 && yS == 10'd4) begin
        found = 1'b1;
        break;
      end
      step();
    end
    checks++;
    if (!found || fcS !== 8'd1 || vsS !== 1'b0 || hsS !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midsync_setup got found=%0d fc=%0d vs=%b hs=%b exp 1 1 0 0", found, fcS, vsS, hsS);
    end
    rst = 1'b1;
    step();
    checks++;
    if ({xS, yS, fcS, hsS, vsS, actS} !== {10'd0, 10'd0, 8'd0, 3'b110}) begin
      failures++;
      $display("[TB] FAIL midsync_reset_small got x=%0d y=%0d fc=%0d sync=%b exp 0 0 0 110", xS, yS, fcS, {hsS, vsS, actS});
    end
    checks++;
    if ({xD, yD, fcD, hsD, vsD, actD, hsT, vsT, actT} !== {10'd0, 10'd0, 8'd0, 6'b110110}) begin
      failures++;
      $display("[TB] FAIL midsync_reset_default got x=%0d y=%0d fc=%0d sync=%b exp 0 0 0 110110", xD, yD, fcD, {hsD, vsD, actD, hsT, vsT, actT});
    end
    rst = 1'b0;
    step();
    checks++;
    if ({xS, xD, actS} !== {10'd1, 10'd1, 1'b1}) begin
      failures++;
      $display("[TB] FAIL post_reset_edge got xS=%0d xD=%0d actS=%b exp 1 1 1", xS, xD, actS);
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_release();
    test_line_timing();
    test_small_frame();
    test_frame_wrap();
    test_reset_midsync();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
